// File: rtl/vram_pkg.sv
// Shared defaults, transfer-mode constants and FSM state encoding for the VRAM loader.
package vram_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 8;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/vram_loader_if.sv
// Host control, image-ROM read port and video-RAM write port of the VRAM loader as one bundle.
interface vram_loader_if
   import vram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              start;
   logic              abort;
   logic              mode;
   logic [DATA_W-1:0] fill_value;
   logic              write_allow;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              ram_ce;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, mode, fill_value, write_allow, rom_data,
      input  rom_addr, ram_ce, ram_addr, ram_data, busy, done
   );

   modport slave (
      input  start, abort, mode, fill_value, write_allow, rom_data,
      output rom_addr, ram_ce, ram_addr, ram_data, busy, done
   );

endinterface

// File: rtl/vram_loader.sv
// Fills video RAM from the image ROM (copy, 2+ROM_LAT cycles/byte) or with a constant byte (fill, 1 cycle/byte).
// write_allow low stalls in WRITE with address/data held; abort returns to IDLE at once without a done pulse.
module vram_loader
   import vram_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROM_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   vram_loader_if.slave bus
);

   localparam int                WCNT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(ROM_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t              state_q;
   logic                mode_q;
   logic [DATA_W-1:0]   fill_q;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic [WCNT_W-1:0]   wcnt_q;
   logic                busy_q;
   logic                done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_COPY;
         fill_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         rom_addr_q <= '0;
         wcnt_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (bus.abort && (state_q != IDLE)) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  mode_q <= bus.mode;
                  fill_q <= bus.fill_value;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (bus.mode == MODE_FILL) begin
                     state_q <= WRITE;
                  end else begin
                     rom_addr_q <= '0;
                     state_q    <= FETCH;
                  end
               end
            end
            FETCH: begin
               wcnt_q  <= WAIT_LOAD;
               state_q <= WAIT;
            end
            WAIT: begin
               // Count down so the capture lands on the ROM's last latency cycle.
               if (wcnt_q == '0) begin
                  data_q  <= bus.rom_data;
                  state_q <= WRITE;
               end else begin
                  wcnt_q <= wcnt_q - 1'b1;
               end
            end
            WRITE: begin
               if (bus.write_allow) begin
                  if (cnt_q == LAST_ADDR) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     if (mode_q == MODE_COPY) begin
                        rom_addr_q <= cnt_q + 1'b1;
                        state_q    <= FETCH;
                     end
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobe is qualified live so a write slot is never used after write_allow, abort or rst drops.
   assign bus.ram_ce   = (state_q == WRITE) && bus.write_allow && !bus.abort && !rst;
   assign bus.ram_addr = cnt_q;
   assign bus.ram_data = (mode_q == MODE_FILL) ? fill_q : data_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_vram_loader.sv
// Bench for vram_loader: table-driven transfers plus randomized runs, checked against a cycle-level write-slot model.
module tb_vram_loader;
   import vram_pkg::*;

   localparam int AW = 11;
   localparam int DW = 8;
   localparam int N  = 2048;

   typedef struct packed {
      logic          ce;
      logic          busy;
      logic          done;
      logic [AW-1:0] rom_addr;
      logic [AW-1:0] ram_addr;
      logic [DW-1:0] ram_data;
   } obs_t;

   typedef struct {
      int            sel;
      logic          md;
      logic [DW-1:0] fv;
      int            wa_kind;
      int            abort_at;
      int            glitch_at;
      int            exp_wr;
      int            exp_done;
   } vec_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   vram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   vram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   vram_loader #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   vram_loader #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   logic [DW-1:0] rom_mem [2][N];
   logic [DW-1:0] pipe_a;
   logic [DW-1:0] pipe_b [3];

   always_ff @(posedge clk) begin
      pipe_a    <= rom_mem[0][bus_a.rom_addr];
      pipe_b[0] <= rom_mem[1][bus_b.rom_addr];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign bus_a.rom_data = pipe_a;
   assign bus_b.rom_data = pipe_b[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic ab, input logic md,
                        input logic [DW-1:0] fv, input logic wa);
      if (sel == 0) begin
         bus_a.start = st; bus_a.abort = ab; bus_a.mode = md;
         bus_a.fill_value = fv; bus_a.write_allow = wa;
      end else begin
         bus_b.start = st; bus_b.abort = ab; bus_b.mode = md;
         bus_b.fill_value = fv; bus_b.write_allow = wa;
      end
   endtask

   function automatic obs_t sample(input int sel);
      obs_t o;
      if (sel == 0) begin
         o.ce = bus_a.ram_ce; o.busy = bus_a.busy; o.done = bus_a.done;
         o.rom_addr = bus_a.rom_addr; o.ram_addr = bus_a.ram_addr; o.ram_data = bus_a.ram_data;
      end else begin
         o.ce = bus_b.ram_ce; o.busy = bus_b.busy; o.done = bus_b.done;
         o.rom_addr = bus_b.rom_addr; o.ram_addr = bus_b.ram_addr; o.ram_data = bus_b.ram_data;
      end
      return o;
   endfunction

   // Model: byte k may be written at the first cycle >= t_ready with write_allow high,
   // where t_ready starts at one byte period after start and advances one period past each write.
   task automatic run_xfer(input int sel, input logic md, input logic [DW-1:0] fv, input int wa_kind,
                           input int abort_at, input int glitch_at, output int n_wr, output int done_cyc);
      int            lat, per, exp_addr, t_ready, fin_cyc, ab_cyc, limit;
      logic          wa, ab, active, exp_ce, exp_done;
      logic [DW-1:0] exp_byte;
      obs_t          o;
      lat      = (sel == 0) ? 1 : 3;
      per      = md ? 1 : 2 + lat;
      exp_addr = 0;
      t_ready  = per;
      fin_cyc  = -1;
      ab_cyc   = (abort_at == 0) ? 0 : -1;
      limit    = 8 * N * per + 100;
      n_wr     = 0;
      done_cyc = -1;
      @(posedge clk); #1;
      drive(sel, 1'b1, abort_at == 0, md, fv, 1'b0);
      for (int c = 1; c < limit; c++) begin
         @(posedge clk); #1;
         case (wa_kind)
            0:       wa = 1'b1;
            1:       wa = ((c % 4) == 1);
            default: wa = ($urandom_range(3) != 0);
         endcase
         ab = (c == abort_at);
         drive(sel, c == glitch_at, ab, ~md, ~fv, wa);
         @(negedge clk);
         o        = sample(sel);
         active   = (ab_cyc < 0) && (fin_cyc < 0);
         exp_ce   = active && !ab && wa && (c >= t_ready);
         exp_done = (fin_cyc >= 0) && (c == fin_cyc + 1);
         chk($sformatf("ram_ce sel=%0d c=%0d", sel, c), o.ce, exp_ce);
         chk($sformatf("busy sel=%0d c=%0d", sel, c), o.busy, active);
         chk($sformatf("done sel=%0d c=%0d", sel, c), o.done, exp_done);
         if (active && c >= t_ready) begin
            exp_byte = md ? fv : rom_mem[sel][exp_addr];
            chk($sformatf("ram_addr sel=%0d c=%0d", sel, c), o.ram_addr, exp_addr);
            chk($sformatf("ram_data sel=%0d c=%0d", sel, c), o.ram_data, exp_byte);
            if (!md) chk($sformatf("rom_addr sel=%0d c=%0d", sel, c), o.rom_addr, exp_addr);
         end
         if (o.ce) n_wr++;
         if (o.done && done_cyc < 0) done_cyc = c;
         if (exp_ce) begin
            exp_addr++;
            t_ready = c + per;
            if (exp_addr == N) fin_cyc = c;
         end
         if (ab && active) ab_cyc = c;
         if ((fin_cyc >= 0 && c >= fin_cyc + 4) || (ab_cyc >= 0 && c >= ab_cyc + 10)) break;
      end
      chk($sformatf("transfer ended within budget sel=%0d", sel), (fin_cyc >= 0) || (ab_cyc >= 0), 1'b1);
      drive(sel, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      vec_t vecs [7];
      obs_t o;
      int   nw, dc, sel, ab_at;
      logic md;
      logic [DW-1:0] fv;

      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int a = 0; a < N; a++) begin
         rom_mem[0][a] = a[7:0];
         rom_mem[1][a] = 8'($urandom);
      end

      //          sel md    fill   wa  abort glitch writes done
      vecs[0] = '{0, MODE_COPY, 8'h00, 0, -1,  -1,  2048, 3*2048+1};
      vecs[1] = '{0, MODE_FILL, 8'hA5, 1, -1,  -1,  2048, 8190};
      vecs[2] = '{0, MODE_COPY, 8'h00, 0, 303, -1,  100,  -1};
      vecs[3] = '{0, MODE_COPY, 8'h00, 0, 30,  -1,  9,    -1};
      vecs[4] = '{0, MODE_FILL, 8'h3C, 0, -1,  11,  2048, 2049};
      vecs[5] = '{0, MODE_COPY, 8'h00, 0, 0,   -1,  0,    -1};
      vecs[6] = '{1, MODE_COPY, 8'h00, 0, -1,  -1,  2048, 5*2048+1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         o = sample(s);
         chk($sformatf("reset ram_ce sel=%0d", s), o.ce, 1'b0);
         chk($sformatf("reset busy sel=%0d", s), o.busy, 1'b0);
         chk($sformatf("reset done sel=%0d", s), o.done, 1'b0);
         chk($sformatf("reset rom_addr sel=%0d", s), o.rom_addr, 0);
         chk($sformatf("reset ram_addr sel=%0d", s), o.ram_addr, 0);
         chk($sformatf("reset ram_data sel=%0d", s), o.ram_data, 0);
      end

      for (int i = 0; i < 7; i++) begin
         run_xfer(vecs[i].sel, vecs[i].md, vecs[i].fv, vecs[i].wa_kind,
                  vecs[i].abort_at, vecs[i].glitch_at, nw, dc);
         chk($sformatf("vec%0d write count", i), nw, vecs[i].exp_wr);
         chk($sformatf("vec%0d done cycle", i), dc, vecs[i].exp_done);
         repeat (2) @(posedge clk);
      end

      // Reset while stalled in WRITE after six copied bytes.
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, MODE_COPY, '0, 1'b1);
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         drive(0, 1'b0, 1'b0, MODE_COPY, '0, c <= 20);
      end
      @(negedge clk);
      o = sample(0);
      chk("stall ram_ce", o.ce, 1'b0);
      chk("stall busy", o.busy, 1'b1);
      chk("stall ram_addr", o.ram_addr, 6);
      chk("stall rom_addr", o.rom_addr, 6);
      chk("stall ram_data", o.ram_data, 8'h06);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      o = sample(0);
      chk("post-rst ram_ce", o.ce, 1'b0);
      chk("post-rst busy", o.busy, 1'b0);
      chk("post-rst done", o.done, 1'b0);
      chk("post-rst rom_addr", o.rom_addr, 0);
      chk("post-rst ram_addr", o.ram_addr, 0);
      chk("post-rst ram_data", o.ram_data, 0);
      run_xfer(0, MODE_COPY, '0, 0, -1, -1, nw, dc);
      chk("post-rst copy write count", nw, 2048);
      chk("post-rst copy done cycle", dc, 3*2048+1);
      repeat (2) @(posedge clk);

      for (int r = 0; r < 5; r++) begin
         sel   = int'($urandom_range(1));
         md    = 1'($urandom_range(1));
         fv    = 8'($urandom);
         ab_at = (r < 4) ? int'($urandom_range(1500, 1)) : -1;
         for (int a = 0; a < N; a++) rom_mem[sel][a] = 8'($urandom);
         run_xfer(sel, md, fv, 2, ab_at, -1, nw, dc);
         if (ab_at < 0) begin
            chk($sformatf("rand%0d write count", r), nw, 2048);
            chk($sformatf("rand%0d done seen", r), dc >= 0, 1'b1);
         end else begin
            chk($sformatf("rand%0d no done after abort", r), dc, -1);
         end
         repeat (2) @(posedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_loader.md
VRAM_LOADER -- requirements
Module: vram_loader

Interface
REQ-001 Parameter ADDR_W, default 11, sets the video RAM / image ROM word-address width (2**ADDR_W bytes per transfer).
REQ-002 Parameter DATA_W, default 8, sets the pixel byte width.
REQ-003 Parameter ROM_LAT, default 1, sets the image ROM read latency in clk cycles (range 1..3).
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 abort  in  1  terminates any transfer; sampled in every state.
REQ-008 mode  in  1  0 = copy ROM to RAM, 1 = fill RAM with fill_value; latched on accepted start.
REQ-009 fill_value  in  DATA_W  fill byte; latched on accepted start.
REQ-010 write_allow  in  1  high when the RAM write port may be used (display blanking).
REQ-011 rom_addr  out  ADDR_W  image ROM read address.
REQ-012 rom_data  in  DATA_W  image ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-013 ram_ce  out  1  video RAM write strobe, one byte per high cycle.
REQ-014 ram_addr  out  ADDR_W  video RAM write address.
REQ-015 ram_data  out  DATA_W  video RAM write data.
REQ-016 busy  out  1  high from the cycle after an accepted start until the transfer ends.
REQ-017 done  out  1  single-cycle pulse on normal completion (never on abort).

Function
REQ-018 The FSM states SHALL be IDLE, FETCH, WAIT, WRITE, DONE.
REQ-019 IDLE: start=1 and abort=0 -> latch mode/fill_value, clear the address counter to 0, go to FETCH (mode 0) or WRITE (mode 1).
REQ-020 FETCH: drive rom_addr = counter for one cycle, then go to WAIT; rom_addr holds its value until the next FETCH.
REQ-021 WAIT: stay ROM_LAT cycles, capture rom_data into the data register on the last cycle, then go to WRITE.
REQ-022 WRITE: when write_allow=1, assert ram_ce for exactly one cycle with ram_addr = counter and ram_data = captured byte (mode 0) or fill_value (mode 1).
REQ-023 WRITE: when write_allow=0, hold the state with ram_ce=0 and ram_addr/ram_data stable.
REQ-024 After a write with counter < 2**ADDR_W-1, increment the counter and go to FETCH (mode 0) or stay in WRITE (mode 1).
REQ-025 After a write with counter = 2**ADDR_W-1, go to DONE; the counter SHALL NOT wrap to 0 and rewrite.
REQ-026 DONE: pulse done=1 for one cycle with busy=0, then go to IDLE.
REQ-027 Throughput with write_allow held high: mode 0 = 2+ROM_LAT cycles per byte; mode 1 = 1 cycle per byte.
REQ-028 start while not in IDLE SHALL be ignored, with no effect on the counter, mode or data.
REQ-029 abort=1 in any non-IDLE state: next state IDLE, ram_ce=0 in that cycle and after, busy=0 next cycle, no done pulse.
REQ-030 abort and start high together in IDLE: abort wins and no transfer starts.
REQ-031 ram_ce SHALL never be high outside WRITE or while write_allow=0.

Reset
REQ-032 rst=1 SHALL force IDLE regardless of state, including mid-transfer.
REQ-033 rst=1 SHALL clear rom_addr, ram_addr, ram_data, the counter, the latched mode and the latched fill_value to 0.
REQ-034 rst=1 SHALL drive ram_ce=0, busy=0 and done=0 on the first clock after reset is sampled.
REQ-035 rst SHALL take priority over start and abort.

Structure
REQ-036 Package vram_pkg SHALL hold the ADDR_W/DATA_W defaults, the state enum and the MODE_COPY/MODE_FILL constants.
REQ-037 The block SHALL be one module with no sub-modules; the WAIT delay SHALL use a small down-counter sized for ROM_LAT.

Verification
REQ-038 Copy with ROM_LAT=1, write_allow=1, ROM[a]=a[7:0]: exactly 2048 ram_ce pulses, 3 cycles apart, ram_data=ram_addr[7:0], done at cycle 3*2048+1.
REQ-039 Fill with fill_value=8'hA5, write_allow toggling 1 cycle high / 3 cycles low: 2048 writes of 8'hA5, each only when write_allow=1, with addresses strictly ascending.
REQ-040 Abort at byte 100 of a copy: no ram_ce after the abort cycle, busy=0 next cycle, no done pulse; a new start then writes from address 0.
REQ-041 start pulsed at byte 10 of a fill, and start+abort together in IDLE: transfer unaffected / no transfer; the write count is checked in both cases.
REQ-042 rst asserted mid-WRITE with write_allow=0: next cycle all outputs 0 and state IDLE; a copy after release completes normally.
REQ-043 ROM_LAT=3 copy: ram_data equals ROM contents at every address, with 5 cycles per byte.
